// File: rtl/alu_pkg.sv
// alu_pkg: shared shift-op, sequencer state and ALU control encodings
package alu_pkg;
  typedef enum logic [2:0] {
    OP_RLC = 3'd0, OP_RRC = 3'd1, OP_RL = 3'd2, OP_RR = 3'd3,
    OP_SLA = 3'd4, OP_SRA = 3'd5, OP_SWAP = 3'd6, OP_SRL = 3'd7
  } shift_op_e;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_RESULT, S_DONE} state_e;
  typedef enum logic [1:0] {NO_SH, L_SH, R_SH} sh_e;
  typedef enum logic [1:0] {NO_OE, SH_OE, RES_OE} oe_e;
  typedef enum logic {NO_LD, BUS_LD} ld_e;
endpackage

// File: rtl/alu_shift_seq_if.sv
// alu_shift_seq_if: request handshake, ALU control word and result bus
interface alu_shift_seq_if import alu_pkg::*; ();
  logic       req_valid, req_ready, req_cf;
  logic [2:0] req_op;
  logic [7:0] req_b;
  logic [7:0] alu_op;
  logic       alu_si;
  sh_e        alu_sh;
  oe_e        alu_oe;
  ld_e        alu_la, alu_lb;
  logic       alu_r, alu_s, alu_v, alu_ne, alu_ci, alu_l, alu_h;
  logic       alu_shift_dbh, alu_zero;
  logic [7:0] alu_result;
  logic       done, err, flag_z, flag_n, flag_h, flag_c;
  logic [7:0] res;
  modport slave (
    input  req_valid, req_op, req_b, req_cf, alu_shift_dbh, alu_result, alu_zero,
    output req_ready, alu_op, alu_si, alu_sh, alu_oe, alu_la, alu_lb, alu_r, alu_s,
           alu_v, alu_ne, alu_ci, alu_l, alu_h, done, res, flag_z, flag_n, flag_h,
           flag_c, err
  );
  modport master (
    output req_valid, req_op, req_b, req_cf, alu_shift_dbh, alu_result, alu_zero,
    input  req_ready, alu_op, alu_si, alu_sh, alu_oe, alu_la, alu_lb, alu_r, alu_s,
           alu_v, alu_ne, alu_ci, alu_l, alu_h, done, res, flag_z, flag_n, flag_h,
           flag_c, err
  );
endinterface

// File: rtl/alu_shift_decode.sv
// alu_shift_decode: maps a shift op to its shift-in bit and direction
module alu_shift_decode import alu_pkg::*; (
  input  shift_op_e  i_op,
  input  logic [7:0] i_b,
  input  logic       i_cf,
  output logic       o_si,
  output sh_e        o_sh
);
  // rotates feed back the outgoing end, RL/RR feed carry, SRA replicates sign
  always_comb begin
    o_si = (i_op == OP_RLC || i_op == OP_SRA) ? i_b[7] :
           (i_op == OP_RRC) ? i_b[0] :
           (i_op == OP_RL || i_op == OP_RR) ? i_cf : 1'b0;
    o_sh = (i_op == OP_RLC || i_op == OP_RL || i_op == OP_SLA) ? L_SH : R_SH;
  end
endmodule

// File: rtl/alu_shift_seq.sv
// alu_shift_seq: sequences a CB-prefix shift/rotate through the ALU in three cycles
module alu_shift_seq import alu_pkg::*; (
  input logic clk,
  input logic reset,
  alu_shift_seq_if.slave bus
);
  state_e     r_state, w_next;
  shift_op_e  r_op;
  logic [7:0] r_b, r_res;
  logic       r_cf, r_carry, r_err, r_z, r_c;
  logic       w_rdy, w_acc, w_legal, w_shift, w_result, w_si;
  sh_e        w_sh;

  alu_shift_decode u_dec (.i_op(r_op), .i_b(r_b), .i_cf(r_cf), .o_si(w_si), .o_sh(w_sh));

  // state register
  always_ff @(posedge clk)
    r_state <= reset ? S_IDLE : w_next;

  // acceptance and next state; a reserved op is consumed without starting a sequence
  always_comb begin
    w_rdy    = r_state == S_IDLE || r_state == S_DONE;
    w_acc    = bus.req_valid && w_rdy;
    w_legal  = w_acc && bus.req_op != OP_SWAP;
    w_shift  = r_state == S_SHIFT;
    w_result = r_state == S_RESULT;
    w_next   = w_legal ? S_SHIFT : w_shift ? S_RESULT : w_result ? S_DONE : S_IDLE;
  end

  // operand capture, carry/result latching and error pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op    <= OP_RLC;
      r_b     <= '0;
      r_cf    <= 1'b0;
      r_carry <= 1'b0;
      r_err   <= 1'b0;
      r_res   <= '0;
      r_z     <= 1'b0;
      r_c     <= 1'b0;
    end else begin
      r_err <= w_acc && !w_legal;
      if (w_legal) begin
        r_op <= shift_op_e'(bus.req_op);
        r_b  <= bus.req_b;
        r_cf <= bus.req_cf;
      end
      if (w_shift) r_carry <= bus.alu_shift_dbh;
      if (w_result) begin
        r_res <= bus.alu_result;
        r_z   <= bus.alu_zero;
        r_c   <= r_carry;
      end
    end
  end

  // ALU control word and status outputs, idle word outside SHIFT/RESULT
  always_comb begin
    bus.req_ready = w_rdy;
    bus.alu_op    = w_shift ? r_b : '0;
    bus.alu_si    = w_shift && w_si;
    bus.alu_sh    = w_shift ? w_sh : NO_SH;
    bus.alu_oe    = w_shift ? SH_OE : w_result ? RES_OE : NO_OE;
    bus.alu_la    = w_shift ? BUS_LD : NO_LD;
    bus.alu_lb    = w_shift ? BUS_LD : NO_LD;
    bus.alu_r     = w_shift || w_result;
    bus.alu_s     = w_shift || w_result;
    bus.alu_v     = w_shift || w_result;
    bus.alu_ne    = 1'b0;
    bus.alu_ci    = 1'b0;
    bus.alu_l     = w_shift;
    bus.alu_h     = w_result;
    bus.done      = r_state == S_DONE;
    bus.err       = r_err;
    bus.res       = r_res;
    bus.flag_z    = r_z;
    bus.flag_c    = r_c;
    bus.flag_n    = 1'b0;
    bus.flag_h    = 1'b0;
  end
endmodule

// File: tb/tb_alu_shift_seq.sv
// tb_alu_shift_seq: random and directed checks of alu_shift_seq against a cycle-count model
module tb_alu_shift_seq;
  import alu_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_shift_seq_if bus();
  alu_shift_seq dut (.clk(clk), .reset(reset), .bus(bus));

  logic [7:0] alu_reg = 8'h00;
  always_comb begin
    bus.alu_shift_dbh = bus.alu_sh == L_SH ? bus.alu_op[7] : bus.alu_sh == R_SH ? bus.alu_op[0] : 1'b0;
    bus.alu_result    = alu_reg;
    bus.alu_zero      = alu_reg == 8'h00;
  end
  always @(posedge clk)
    if (bus.alu_la == BUS_LD && bus.alu_oe == SH_OE)
      alu_reg <= bus.alu_sh == L_SH ? {bus.alu_op[6:0], bus.alu_si} : {bus.alu_si, bus.alu_op[7:1]};

  int errs = 0, checks = 0;
  int cyc = 0, acc = -10, err_at = -10, d;
  logic [7:0] p_b, p_res, e_res;
  logic p_c, p_si, p_left, e_z, e_c;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [8:0] ref_shift(input int op, input int b, input int cf);
    int r, c;
    case (op)
      0: begin r = (b * 2) % 256 + b / 128; c = b / 128; end
      1: begin r = b / 2 + (b % 2) * 128;   c = b % 2;   end
      2: begin r = (b * 2) % 256 + cf;      c = b / 128; end
      3: begin r = b / 2 + cf * 128;        c = b % 2;   end
      4: begin r = (b * 2) % 256;           c = b / 128; end
      5: begin r = b / 2 + (b / 128) * 128; c = b % 2;   end
      default: begin r = b / 2;             c = b % 2;   end
    endcase
    return 9'(c * 256 + r);
  endfunction

  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    if (reset) begin
      acc = -10; err_at = -10; e_res = 8'h00; e_z = 1'b0; e_c = 1'b0;
    end else begin
      d = cyc - 1 - acc;
      if (bus.req_valid && d != 0 && d != 1) begin
        if (bus.req_op == 3'd6) err_at = cyc;
        else begin
          acc = cyc;
          p_b = bus.req_b;
          {p_c, p_res} = ref_shift(int'(bus.req_op), int'(bus.req_b), int'(bus.req_cf));
          p_left = bus.req_op == 3'd0 || bus.req_op == 3'd2 || bus.req_op == 3'd4;
          p_si = p_left ? p_res[0] : p_res[7];
        end
      end
      if (cyc - acc == 2) begin
        e_res = p_res; e_z = p_res == 8'h00; e_c = p_c;
      end
    end
    d = cyc - acc;
    chk("ready", bus.req_ready, d != 0 && d != 1);
    chk("done", bus.done, d == 2);
    chk("err", bus.err, err_at == cyc);
    chk("res", bus.res, e_res);
    chk("flag_z", bus.flag_z, e_z);
    chk("flag_c", bus.flag_c, e_c);
    chk("flag_nh", {bus.flag_n, bus.flag_h}, 0);
    if (d == 0) begin
      chk("shift_op", bus.alu_op, p_b);
      chk("shift_si", bus.alu_si, p_si);
      chk("shift_sh", bus.alu_sh, p_left ? L_SH : R_SH);
      chk("shift_oe", bus.alu_oe, SH_OE);
      chk("shift_ld", {bus.alu_la, bus.alu_lb}, 2'b11);
      chk("shift_bits", {bus.alu_r, bus.alu_s, bus.alu_v, bus.alu_ne, bus.alu_ci, bus.alu_l, bus.alu_h}, 7'b1110010);
    end else if (d == 1) begin
      chk("result_oe", bus.alu_oe, RES_OE);
      chk("result_ld", {bus.alu_la, bus.alu_lb}, 2'b00);
      chk("result_bits", {bus.alu_r, bus.alu_s, bus.alu_v, bus.alu_ne, bus.alu_ci, bus.alu_l, bus.alu_h}, 7'b1110001);
    end else begin
      chk("idle_word", {bus.alu_op, bus.alu_si, bus.alu_sh, bus.alu_oe, bus.alu_la, bus.alu_lb}, 0);
      chk("idle_bits", {bus.alu_r, bus.alu_s, bus.alu_v, bus.alu_ne, bus.alu_ci, bus.alu_l, bus.alu_h}, 0);
    end
  end

  task automatic offer(input logic [2:0] op, input logic [7:0] b, input logic cf);
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_b = b; bus.req_cf = cf;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!bus.done && n < 8) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic lit(input logic [2:0] op, input logic [7:0] b, input logic cf, input logic xsi,
                     input sh_e xsh, input logic [7:0] xres, input logic xz, input logic xc);
    int n;
    @(negedge clk);
    offer(op, b, cf);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("lit_si", bus.alu_si, xsi);
    chk("lit_sh", bus.alu_sh, xsh);
    wait_done(n);
    chk("lit_latency", n, 2);
    chk("lit_res", bus.res, xres);
    chk("lit_z", bus.flag_z, xz);
    chk("lit_c", bus.flag_c, xc);
  endtask

  initial begin
    int n;
    bus.req_valid = 1'b0; bus.req_op = 3'd0; bus.req_b = 8'h00; bus.req_cf = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    lit(3'd0, 8'h85, 1'b0, 1'b1, L_SH, 8'h0B, 1'b0, 1'b1);
    lit(3'd3, 8'h01, 1'b1, 1'b1, R_SH, 8'h80, 1'b0, 1'b1);
    lit(3'd4, 8'h80, 1'b0, 1'b0, L_SH, 8'h00, 1'b1, 1'b1);
    lit(3'd5, 8'h80, 1'b0, 1'b1, R_SH, 8'hC0, 1'b0, 1'b0);
    @(negedge clk);
    offer(3'd0, 8'h85, 1'b0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rst_in_result", bus.alu_oe, RES_OE);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", bus.req_ready, 1);
    chk("rst_res", bus.res, 8'h00);
    chk("rst_oe", bus.alu_oe, NO_OE);
    repeat (4) begin
      @(negedge clk);
      chk("rst_no_done", bus.done, 0);
    end
    lit(3'd7, 8'h01, 1'b0, 1'b0, R_SH, 8'h00, 1'b1, 1'b1);
    @(negedge clk);
    offer(3'd6, 8'h55, 1'b0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("swap_err", bus.err, 1);
    chk("swap_ready", bus.req_ready, 1);
    repeat (4) begin
      @(negedge clk);
      chk("swap_no_seq", {bus.done, bus.alu_oe}, 0);
    end
    offer(3'd2, 8'h81, 1'b0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    wait_done(n);
    chk("b2b_first_res", bus.res, 8'h02);
    offer(3'd1, 8'h01, 1'b0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    wait_done(n);
    chk("b2b_gap", n + 1, 3);
    chk("b2b_second_res", bus.res, 8'h80);
    chk("b2b_second_c", bus.flag_c, 1);
    repeat (800) begin
      @(negedge clk);
      reset = $urandom_range(0, 60) == 0;
      offer(3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom));
      bus.req_valid = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    reset = 1'b0;
    bus.req_valid = 1'b0;
    repeat (6) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/alu_shift_seq.md
ALU_SHIFT_SEQ -- requirements
Module: alu_shift_seq

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 req_valid  input  1  requester presents a shift/rotate operation.
REQ-004 req_ready  output  1  sequencer accepts; transfer occurs when req_valid && req_ready at a rising edge.
REQ-005 req_op  input  3  shift op, CB-prefix encoding: 000 RLC, 001 RRC, 010 RL, 011 RR, 100 SLA, 101 SRA, 110 SWAP (reserved), 111 SRL.
REQ-006 req_b  input  8  operand byte.
REQ-007 req_cf  input  1  incoming carry flag, used by RL/RR.
REQ-008 alu_op, alu_si, alu_sh, alu_oe, alu_la, alu_lb, alu_r, alu_s, alu_v, alu_ne, alu_ci, alu_l, alu_h  output  per alu_pkg  ALU control word driven each cycle.
REQ-009 alu_shift_dbh  input  1  bit shifted out by the ALU shifter.
REQ-010 alu_result  input  8  ALU result bus.
REQ-011 alu_zero  input  1  ALU zero detect.
REQ-012 done  output  1  one-cycle pulse; res/flags valid.
REQ-013 res  output  8  registered result.
REQ-014 flag_z, flag_n, flag_h, flag_c  output  1 each  registered result flags.
REQ-015 err  output  1  one-cycle pulse on rejected op.

Function
REQ-016 States IDLE, SHIFT, RESULT, DONE; IDLE->SHIFT on accepted legal op; SHIFT->RESULT; RESULT->DONE; DONE->SHIFT if a legal op is accepted that cycle, else IDLE.
REQ-017 req_ready SHALL be 1 in IDLE and DONE, 0 in SHIFT and RESULT.
REQ-018 Accepted op 110 SHALL NOT start a sequence; err pulses the following cycle; state goes or stays IDLE.
REQ-019 Accept registers req_op, req_b, req_cf internally.
REQ-020 Shift-in bit: RLC b[7]; RRC b[0]; RL/RR cf; SLA 0; SRA b[7]; SRL 0.
REQ-021 Direction: RLC/RL/SLA alu_sh=L_SH; RRC/RR/SRA/SRL alu_sh=R_SH.
REQ-022 SHIFT drives alu_op=b, alu_si per REQ-020, alu_sh per REQ-021, alu_oe=SH_OE, alu_la=alu_lb=BUS_LD, r=s=v=1, ne=0, ci=0, l=1, h=0; latches carry <= alu_shift_dbh.
REQ-023 RESULT drives alu_la=alu_lb=NO_LD, alu_oe=RES_OE, r=s=v=1, ne=0, ci=0, l=0, h=1; latches res <= alu_result, flag_z <= alu_zero.
REQ-024 DONE: done=1; flag_n=0, flag_h=0, flag_c=latched carry.
REQ-025 IDLE/DONE control word: la=lb=NO_LD, oe=NO_OE, sh=NO_SH, all single bits 0, op=0.
REQ-026 Latency: accept at edge t -> SHIFT in cycle t+1, RESULT t+2, done high t+3; sustained throughput one op per 3 cycles.
REQ-027 res and flags SHALL hold until the next RESULT/DONE overwrite them.

Reset
REQ-028 reset SHALL force IDLE, req_ready=1, done=0, err=0, res=0, all flags 0, control word per REQ-025, from the next cycle, regardless of current state.
REQ-029 A sequence interrupted by reset SHALL never produce done.

Structure
REQ-030 Shift-op enum, state enum and ALU control enums (L_SH/R_SH/NO_SH, SH_OE/RES_OE/NO_OE, BUS_LD/NO_LD) SHALL live in alu_pkg.
REQ-031 Op->(si, sh) mapping SHALL be a combinational sub-module alu_shift_decode.

Verification
REQ-032 RLC b=0x85 -> SHIFT si=1 sh=L_SH; done at t+3, res=0x0B, C=1, Z=0.
REQ-033 RR b=0x01 cf=1 -> res=0x80, C=1, Z=0; SLA b=0x80 -> res=0x00, Z=1, C=1.
REQ-034 SRA b=0x80 -> res=0xC0, C=0; SRL b=0x01 -> res=0x00, Z=1, C=1.
REQ-035 op=110 with valid -> err pulse next cycle, no SHIFT/done, ready stays 1.
REQ-036 reset asserted in RESULT -> IDLE next cycle, done never asserted, outputs at reset values.
REQ-037 Back-to-back: second op offered during DONE accepted; its done follows 3 cycles after the first done.
